// File: rtl/usb_tx_arbiter.sv
// Round-robin arbiter that hands the SIE transmit port to one packet source at a
// time, holds it for a whole packet and reports per-source done/timeout.
module usb_tx_arbiter #(
   parameter int REQUESTERS   = 2,
   parameter int DONE_TIMEOUT = 1024,
   parameter int TO_W         = $clog2(DONE_TIMEOUT + 1)
) (
   input  logic                    clk12_i,
   input  logic                    rst_ni,
   input  logic                    enable_i,
   input  logic [REQUESTERS-1:0]   req_i,
   input  logic [REQUESTERS-1:0]   dataValid_i,
   input  logic [REQUESTERS-1:0]   isLastByte_i,
   input  logic [8*REQUESTERS-1:0] data_i,
   output logic [REQUESTERS-1:0]   gnt_o,
   output logic [REQUESTERS-1:0]   acceptNewData_o,
   output logic [REQUESTERS-1:0]   done_o,
   output logic [REQUESTERS-1:0]   timeout_o,
   output logic                    busy_o,
   output logic                    txReqSendPacket_o,
   output logic                    txDataValid_o,
   output logic                    txIsLastByte_o,
   output logic [7:0]              txData_o,
   input  logic                    txAcceptNewData_i,
   input  logic                    txDoneSending_i
);

   localparam int IDX_W = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;

   typedef enum logic [1:0] {IDLE, SEND, WAIT_BUSY, WAIT_DONE} state_t;

   state_t                 state_q, state_d;
   logic [REQUESTERS-1:0]  gnt_q, gnt_d;
   logic [IDX_W-1:0]       idx_q, idx_d;
   logic [IDX_W-1:0]       last_q, last_d;
   logic [TO_W-1:0]        cnt_q, cnt_d;
   logic                   pick_valid;
   logic [IDX_W-1:0]       pick_idx;

   // Round-robin search starts just after the last granted source and wraps at REQUESTERS.
   always_comb begin
      int cand;
      pick_valid = 1'b0;
      pick_idx   = '0;
      cand       = 0;
      for (int off = 1; off <= REQUESTERS; off++) begin
         cand = (int'(last_q) + off) % REQUESTERS;
         if (!pick_valid && req_i[cand]) begin
            pick_valid = 1'b1;
            pick_idx   = IDX_W'(cand);
         end
      end
   end

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
   always_comb begin
      state_d           = state_q;
      gnt_d             = gnt_q;
      idx_d             = idx_q;
      last_d            = last_q;
      cnt_d             = cnt_q;
      txReqSendPacket_o = 1'b0;
      txDataValid_o     = 1'b0;
      txIsLastByte_o    = 1'b0;
      txData_o          = 8'h00;
      acceptNewData_o   = '0;
      done_o            = '0;
      timeout_o         = '0;

      unique case (state_q)
         IDLE: begin
            if (enable_i && pick_valid) begin
               state_d         = SEND;
               gnt_d           = '0;
               gnt_d[pick_idx] = 1'b1;
               idx_d           = pick_idx;
               last_d          = pick_idx;
            end
         end

         SEND: begin
            txReqSendPacket_o = 1'b1;
            txDataValid_o     = dataValid_i[idx_q];
            txIsLastByte_o    = isLastByte_i[idx_q];
            txData_o          = data_i[8*idx_q +: 8];
            acceptNewData_o   = gnt_q & {REQUESTERS{txAcceptNewData_i}};
            if (txDataValid_o && txAcceptNewData_i && txIsLastByte_o) begin
               state_d = WAIT_BUSY;
               cnt_d   = '0;
            end
         end

         WAIT_BUSY, WAIT_DONE: begin
            if (cnt_q == TO_W'(DONE_TIMEOUT)) begin
               timeout_o = gnt_q;
               gnt_d     = '0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + TO_W'(1);
               // A done level still high from the previous packet must drop before it counts.
               if (state_q == WAIT_BUSY && !txDoneSending_i) begin
                  state_d = WAIT_DONE;
               end else if (state_q == WAIT_DONE && txDoneSending_i) begin
                  done_o  = gnt_q;
                  gnt_d   = '0;
                  state_d = IDLE;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk12_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         idx_q   <= '0;
         last_q  <= IDX_W'(REQUESTERS - 1);
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         idx_q   <= idx_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
      end
   end

   assign gnt_o  = gnt_q;
   assign busy_o = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// Directed-plus-random bench for usb_tx_arbiter; expectations come from a
// packet-level model of the round-robin pointer and each source's byte queue.
module tb_usb_tx_arbiter;

   localparam int N  = 2;
   localparam int TO = 1024;
   localparam int DW = 8 * N;

   logic          clk12_i = 1'b0;
   logic          rst_ni;
   logic          enable_i;
   logic [N-1:0]  req_i, dataValid_i, isLastByte_i;
   logic [DW-1:0] data_i;
   logic [N-1:0]  gnt_o, acceptNewData_o, done_o, timeout_o;
   logic          busy_o, txReqSendPacket_o, txDataValid_o, txIsLastByte_o;
   logic [7:0]    txData_o;
   logic          txAcceptNewData_i, txDoneSending_i;

   usb_tx_arbiter #(.REQUESTERS(N), .DONE_TIMEOUT(TO)) dut (
      .clk12_i           (clk12_i),
      .rst_ni            (rst_ni),
      .enable_i          (enable_i),
      .req_i             (req_i),
      .dataValid_i       (dataValid_i),
      .isLastByte_i      (isLastByte_i),
      .data_i            (data_i),
      .gnt_o             (gnt_o),
      .acceptNewData_o   (acceptNewData_o),
      .done_o            (done_o),
      .timeout_o         (timeout_o),
      .busy_o            (busy_o),
      .txReqSendPacket_o (txReqSendPacket_o),
      .txDataValid_o     (txDataValid_o),
      .txIsLastByte_o    (txIsLastByte_o),
      .txData_o          (txData_o),
      .txAcceptNewData_i (txAcceptNewData_i),
      .txDoneSending_i   (txDoneSending_i)
   );

   always #5 clk12_i = ~clk12_i;

   int n_pass  = 0;
   int n_total = 0;
   int n_fail  = 0;
   int last_m  = N - 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk12_i);
      #1;
   endtask

   function automatic int pick(input logic [N-1:0] r, input int last);
      for (int off = 1; off <= N; off++) begin
         int c;
         c = (last + off) % N;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   // One whole packet: grant, byte stream with random stalls, then completion or timeout.
   task automatic do_packet(input int nbytes, input int done_low, input bit stale,
                            input logic [N-1:0] req_mid, input bit fixed);
      logic [7:0]   fx [3];
      logic [7:0]   b  [$];
      logic [N-1:0] oh;
      int           src, idx, guard;
      bit           v, a;
      fx  = '{8'hC3, 8'h01, 8'h02};
      src = pick(req_i, last_m);
      oh  = '0;
      oh[src] = 1'b1;
      for (int i = 0; i < nbytes; i++)
         b.push_back(fixed ? fx[i] : 8'($urandom_range(0, 255)));

      tick();
      check("grant", 32'(gnt_o), 32'(oh));
      check("busy_send", 32'(busy_o), 32'd1);
      req_i = req_mid;

      idx   = 0;
      guard = 0;
      while (idx < nbytes && guard < 200) begin
         v = ($urandom_range(0, 3) != 0);
         a = ($urandom_range(0, 2) != 0);
         dataValid_i           = N'($urandom);
         isLastByte_i          = N'($urandom);
         data_i                = DW'($urandom);
         dataValid_i[src]      = v;
         isLastByte_i[src]     = (idx == nbytes - 1);
         data_i[8*src +: 8]    = b[idx];
         txAcceptNewData_i     = a;
         #1;
         check("tx_req", 32'(txReqSendPacket_o), 32'd1);
         check("tx_valid", 32'(txDataValid_o), 32'(v));
         if (v) begin
            check("tx_data", 32'(txData_o), 32'(b[idx]));
            check("tx_last", 32'(txIsLastByte_o), 32'(idx == nbytes - 1));
         end
         check("accept_route", 32'(acceptNewData_o), a ? 32'(oh) : 32'd0);
         check("gnt_hold", 32'(gnt_o), 32'(oh));
         if (v && a) idx++;
         guard++;
         tick();
      end
      if (idx < nbytes) check("byte_budget", 32'(idx), 32'(nbytes));

      dataValid_i       = '0;
      isLastByte_i      = '0;
      txAcceptNewData_i = 1'b0;
      if (!stale) begin
         txDoneSending_i = 1'b1;
         #1;
         check("wait_txreq", 32'(txReqSendPacket_o), 32'd0);
         check("wait_txdata", {23'd0, txDataValid_o, txData_o}, 32'd0);
         check("wait_gnt", 32'(gnt_o), 32'(oh));
         check("stale_nodone", 32'(done_o), 32'd0);
         tick();
         txDoneSending_i = 1'b0;
         #1;
         check("low_nodone", 32'(done_o), 32'd0);
         tick();
         for (int i = 1; i < done_low; i++) begin
            #1;
            check("waitdone_nodone", 32'({done_o, timeout_o}), 32'd0);
            tick();
         end
         txDoneSending_i = 1'b1;
         #1;
         check("done_pulse", 32'(done_o), 32'(oh));
         check("done_no_timeout", 32'(timeout_o), 32'd0);
         tick();
      end else begin
         txDoneSending_i = 1'b1;
         for (int c = 0; c <= TO; c++) begin
            #1;
            if (c < TO) begin
               check("stale_quiet", 32'({done_o, timeout_o}), 32'd0);
            end else begin
               check("timeout_pulse", 32'(timeout_o), 32'(oh));
               check("timeout_no_done", 32'(done_o), 32'd0);
            end
            tick();
         end
      end
      #1;
      check("gnt_cleared", 32'(gnt_o), 32'd0);
      check("idle_busy", 32'(busy_o), 32'd0);
      check("pulse_1cyc", 32'({done_o, timeout_o}), 32'd0);
      last_m = src;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_ni            = 1'b0;
      enable_i          = 1'b0;
      req_i             = '0;
      dataValid_i       = '0;
      isLastByte_i      = '0;
      data_i            = '0;
      txAcceptNewData_i = 1'b0;
      txDoneSending_i   = 1'b1;
      #3;
      check("rst_gnt", 32'(gnt_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      check("rst_pulses", 32'({done_o, timeout_o, acceptNewData_o}), 32'd0);
      check("rst_tx", {21'd0, txReqSendPacket_o, txDataValid_o, txIsLastByte_o, txData_o}, 32'd0);
      #9 rst_ni = 1'b1;

      // Requests while disabled never win a grant.
      req_i = 2'b11;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("disabled_gnt", 32'(gnt_o), 32'd0);
         check("disabled_busy", 32'(busy_o), 32'd0);
      end
      enable_i = 1'b1;
      #1;
      check("enable_latency", 32'(gnt_o), 32'd0);

      // First packet: fixed bytes C3 01 02 from source 0.
      do_packet(3, 2, 1'b0, 2'b11, 1'b1);

      // Round robin with both sources requesting.
      for (int p = 0; p < 4; p++)
         do_packet($urandom_range(1, 4), $urandom_range(1, 3), 1'b0, 2'b11, 1'b0);

      // Non-preemption: source 0 drops, source 1 rises mid-packet.
      req_i = 2'b01;
      do_packet(4, 2, 1'b0, 2'b10, 1'b0);
      do_packet(2, 1, 1'b0, 2'b10, 1'b0);

      // Random request mixes.
      for (int p = 0; p < 6; p++) begin
         req_i = N'($urandom_range(1, (1 << N) - 1));
         do_packet($urandom_range(1, 5), $urandom_range(1, 4), 1'b0,
                   N'($urandom_range(0, (1 << N) - 1)), 1'b0);
         req_i = N'($urandom_range(1, (1 << N) - 1));
      end

      // Done level stuck high: abort after the timeout window.
      req_i = 2'b11;
      do_packet(2, 1, 1'b1, 2'b11, 1'b0);
      do_packet(1, 1, 1'b0, 2'b11, 1'b0);

      // Async reset in the middle of a packet.
      req_i = 2'b01;
      tick();
      check("pre_reset_gnt", 32'(gnt_o), 32'd1);
      dataValid_i       = 2'b01;
      isLastByte_i      = 2'b00;
      data_i            = 16'h00A5;
      txAcceptNewData_i = 1'b1;
      tick();
      tick();
      rst_ni = 1'b0;
      #1;
      check("midrst_gnt", 32'(gnt_o), 32'd0);
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_tx", {22'd0, txReqSendPacket_o, txDataValid_o, txData_o}, 32'd0);
      check("midrst_pulses", 32'({done_o, timeout_o, acceptNewData_o}), 32'd0);
      #2 rst_ni = 1'b1;
      last_m            = N - 1;
      req_i             = 2'b10;
      dataValid_i       = '0;
      txAcceptNewData_i = 1'b0;
      do_packet(3, 2, 1'b0, 2'b00, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/usb_tx_arbiter.md
Name: usb_tx_arbiter

Overview:
Arbitrates the serial interface engine transmit interface (clk12 domain) between several packet sources, e.g. protocol-engine handshake responder, IN data sender and debug/test injector. Grants one requester at a time by round-robin and holds the grant for a whole atomic packet. After the last byte is handed over, it tracks SIE completion and reports done or timeout per requester. Sits between the packet sources and usb_sie's tx*/txDoneSending ports.

Parameters:
REQUESTERS, 2, number of packet sources (>=2)
DONE_TIMEOUT, 1024, clk12 cycles allowed from last-byte handshake to SIE done before abort
TO_W, $clog2(DONE_TIMEOUT+1), timeout counter width (derived)

Ports:
clk12_i  in  1  12 MHz clock
rst_ni  in  1  asynchronous active-low reset
enable_i  in  1  gates new grants (driven from isSendingPhase)
req_i  in  REQUESTERS  per-source packet request, level
dataValid_i  in  REQUESTERS  per-source byte valid
isLastByte_i  in  REQUESTERS  per-source last-byte flag
data_i  in  8*REQUESTERS  per-source byte, source k at [8k+7:8k]
gnt_o  out  REQUESTERS  one-hot grant, registered
acceptNewData_o  out  REQUESTERS  txAcceptNewData_i routed to granted source only
done_o  out  REQUESTERS  1-cycle pulse: packet fully sent
timeout_o  out  REQUESTERS  1-cycle pulse: SIE done not seen in time
busy_o  out  1  state != IDLE
txReqSendPacket_o  out  1  to SIE
txDataValid_o  out  1  to SIE
txIsLastByte_o  out  1  to SIE
txData_o  out  8  to SIE
txAcceptNewData_i  in  1  from SIE
txDoneSending_i  in  1  from SIE, level, high when SIE tx idle

Behaviour:
- Reset (async, rst_ni=0): state IDLE, gnt_o=0, done_o=0, timeout_o=0, counter=0, RR pointer last=REQUESTERS-1 (source 0 wins first). All tx*_o=0, acceptNewData_o=0.
- States: IDLE, SEND, WAIT_BUSY, WAIT_DONE.
- IDLE: if enable_i && |req_i, pick first requesting k scanning last+1, last+2, ... (mod REQUESTERS). Next cycle gnt_o=onehot(k), last<=k, state SEND. No request or enable_i=0: stay IDLE, 1-cycle grant latency.
- SEND: txReqSendPacket_o=1. txDataValid_o/txIsLastByte_o/txData_o are combinational mux of granted source. acceptNewData_o[k]=txAcceptNewData_i, all others 0. A byte transfers on txDataValid_o && txAcceptNewData_i. A transfer with txIsLastByte_o=1 moves to WAIT_BUSY and clears the counter.
- WAIT_BUSY: txReqSendPacket_o=0, tx data outputs 0, gnt_o held. Go to WAIT_DONE when txDoneSending_i=0 is seen, which rejects a stale done level.
- WAIT_DONE: go to IDLE when txDoneSending_i=1. On that cycle done_o[k] pulses and gnt_o clears next cycle.
- Timeout: counter increments each cycle in WAIT_BUSY/WAIT_DONE, saturating. When it reaches DONE_TIMEOUT: pulse timeout_o[k] (no done_o), go to IDLE, clear gnt_o.
- Grant is non-preemptive. req_i[k] dropping, other requests and enable_i falling mid-packet are all ignored until completion or timeout.
- Ungranted sources' dataValid_i/data_i never reach the SIE.
- done_o and timeout_o are mutually exclusive and at most one bit high at a time.
- Back-to-back: a new grant is possible the cycle after returning to IDLE. Minimum gap between packets is 1 IDLE cycle.
- Reset mid-packet: immediate return to reset values. No done_o/timeout_o is generated.
- REQUESTERS not a power of 2: RR wraps from REQUESTERS-1 to 0.

Test Plan:
- Single source: req_i=01, send 3 bytes 0xC3,0x01,0x02 (last on 3rd), SIE done low 2 cycles then high -> txData_o sequence C3,01,02, txReqSendPacket_o high only in SEND, done_o=01 for exactly 1 cycle, gnt_o=0 after.
- Round-robin: req_i=11 held for 4 packets -> grant order 0,1,0,1. Each packet's bytes come only from the granted source, and acceptNewData_o of the other source stays 0.
- Non-preemption: source 0 granted, req_i[0] drops and req_i[1] rises mid-packet -> source 0 finishes its bytes, done_o[0] pulses, then source 1 is granted.
- Stale done: txDoneSending_i stuck 1 after last byte -> stays in WAIT_BUSY, and after DONE_TIMEOUT=1024 cycles timeout_o[k] pulses with no done_o.
- enable_i=0 with req_i=11 -> no grant, busy_o=0. Raising enable_i -> gnt_o=01 one cycle later.
- Async reset asserted in SEND after byte 2 -> all outputs 0 immediately. After release with req_i=10, source 1 is granted because the pointer restarts at last=REQUESTERS-1 and source 0 is not requesting.
